// File: rtl/fwd_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : fwd_hazard_ctrl_if
// Desc   : ID-stage hazard tags in, EX forwarding selects and stall out.
//          FWD_PERF_EN adds the two performance counters.
// Rev    : 1.0  initial release
// ============================================================================
interface fwd_hazard_ctrl_if #(
    parameter int REG_AW = 5
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic              id_a_imm;
    logic              id_b_imm;
    logic [REG_AW-1:0] id_rd;
    logic              id_reg_write;
    logic              id_mem_read;
    logic              flush;
    logic              mem_busy;
    logic [1:0]        fwd_a_sel;
    logic [1:0]        fwd_b_sel;
    logic              stall;
    logic              ex_bubble;
`ifdef FWD_PERF_EN
    logic [31:0]       perf_stall_cnt;
    logic [31:0]       perf_fwd_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_a_imm, id_b_imm,
               id_rd, id_reg_write, id_mem_read, flush, mem_busy,
        input  fwd_a_sel, fwd_b_sel, stall, ex_bubble, perf_stall_cnt, perf_fwd_cnt
    );
    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_a_imm, id_b_imm,
               id_rd, id_reg_write, id_mem_read, flush, mem_busy,
        output fwd_a_sel, fwd_b_sel, stall, ex_bubble, perf_stall_cnt, perf_fwd_cnt
    );
`else
    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_a_imm, id_b_imm,
               id_rd, id_reg_write, id_mem_read, flush, mem_busy,
        input  fwd_a_sel, fwd_b_sel, stall, ex_bubble
    );
    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_a_imm, id_b_imm,
               id_rd, id_reg_write, id_mem_read, flush, mem_busy,
        output fwd_a_sel, fwd_b_sel, stall, ex_bubble
    );
`endif
endinterface
`default_nettype wire

// File: rtl/fwd_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module : fwd_hazard_ctrl
// Desc   : EX operand-forwarding selects and load-use stall for a 5-stage
//          RV32I pipe; optional counters under FWD_PERF_EN.
// Rev    : 1.0  initial release
// ============================================================================
module fwd_hazard_ctrl #(
    parameter int REG_AW = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    fwd_hazard_ctrl_if.slave bus
);
    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] rd;
        logic              rw;
        logic              mr;
    } tag_t;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_WB  = 2'b10;
    localparam logic [1:0] SEL_IMM = 2'b11;

    logic [0:0] state_q, state_d;
    tag_t       ex_q, mem_q, wb_q, ex_d;
    logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic       ex_bubble_q, ex_bubble_d;
    logic       id_live_w, lu_w, insert_w, advance_w, stall_w;
    logic       unused_wb_w;

    // A load in EX cannot feed 01; it falls through and lu holds ID instead.
    function automatic logic [1:0] fwd_sel(input logic imm, input logic use_rs,
                                           input logic [REG_AW-1:0] rs,
                                           input tag_t ex, input tag_t mem);
        if (imm)
            return SEL_IMM;
        if (use_rs && rs != '0 && ex.v && ex.rw && !ex.mr && rs == ex.rd)
            return SEL_MEM;
        if (use_rs && rs != '0 && mem.v && mem.rw && rs == mem.rd)
            return SEL_WB;
        return SEL_RF;
    endfunction

    assign id_live_w = bus.id_valid & ~bus.flush;
    assign lu_w      = id_live_w & ex_q.v & ex_q.mr & (ex_q.rd != '0) &
                       ((bus.id_use_rs1 & (bus.id_rs1 == ex_q.rd)) |
                        (bus.id_use_rs2 & (bus.id_rs2 == ex_q.rd)));
    assign insert_w  = id_live_w & ~lu_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= ST_RUN;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:  if (bus.mem_busy)  state_d = ST_HOLD;
            ST_HOLD: if (!bus.mem_busy) state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    // The HOLD exit cycle advances like RUN so EX stays in step with IF/ID.
    always_comb begin
        advance_w = 1'b0;
        stall_w   = 1'b0;
        case (state_q)
            ST_RUN: begin
                advance_w = ~bus.mem_busy;
                stall_w   = lu_w | bus.mem_busy;
            end
            ST_HOLD: begin
                advance_w = ~bus.mem_busy;
                stall_w   = bus.mem_busy | lu_w;
            end
            default: begin
                advance_w = 1'b0;
                stall_w   = 1'b0;
            end
        endcase
        if (!rst_n)
            stall_w = 1'b0;
    end

    always_comb begin
        ex_d        = '0;
        fwd_a_d     = SEL_RF;
        fwd_b_d     = SEL_RF;
        ex_bubble_d = 1'b1;
        if (insert_w) begin
            ex_d        = {1'b1, bus.id_rd, bus.id_reg_write, bus.id_mem_read};
            fwd_a_d     = fwd_sel(bus.id_a_imm, bus.id_use_rs1, bus.id_rs1, ex_q, mem_q);
            fwd_b_d     = fwd_sel(bus.id_b_imm, bus.id_use_rs2, bus.id_rs2, ex_q, mem_q);
            ex_bubble_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            fwd_a_q     <= SEL_RF;
            fwd_b_q     <= SEL_RF;
            ex_bubble_q <= 1'b1;
        end else if (advance_w) begin
            wb_q        <= mem_q;
            mem_q       <= ex_q;
            ex_q        <= ex_d;
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
            ex_bubble_q <= ex_bubble_d;
        end
    end

    // WB results reach ID through the write-first regfile, so the WB tag has no consumer here.
    assign unused_wb_w = ^wb_q;

    assign bus.fwd_a_sel = fwd_a_q;
    assign bus.fwd_b_sel = fwd_b_q;
    assign bus.stall     = stall_w;
    assign bus.ex_bubble = ex_bubble_q;

`ifdef FWD_PERF_EN
    logic [31:0] perf_stall_q, perf_fwd_q;
    logic        fwd_hit_w;

    assign fwd_hit_w = (fwd_a_d == SEL_MEM) || (fwd_a_d == SEL_WB) ||
                       (fwd_b_d == SEL_MEM) || (fwd_b_d == SEL_WB);

    // Counted on advancing edges so a load-use held under mem_busy counts once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_q <= '0;
            perf_fwd_q   <= '0;
        end else if (advance_w) begin
            if (lu_w)
                perf_stall_q <= perf_stall_q + 32'd1;
            if (fwd_hit_w)
                perf_fwd_q <= perf_fwd_q + 32'd1;
        end
    end

    assign bus.perf_stall_cnt = perf_stall_q;
    assign bus.perf_fwd_cnt   = perf_fwd_q;
`else
    // Default build carries no counters.
`endif

endmodule
`default_nettype wire
